// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the single-clock FIFO controller and its storage.
//   count_width : width of the occupancy counter for a given pointer width
//   ptr_inc     : pointer increment that wraps at an arbitrary depth
package fifo_pkg;

   // The counter needs one extra bit so it can represent both 0 and MEMORY_DEPTH.
   function automatic int count_width(input int address_size);
      return address_size + 1;
   endfunction

   // The depth need not be a power of two, so wrap explicitly instead of
   // relying on natural pointer overflow.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register file used as FIFO storage.
// Synchronous write, asynchronous read, contents are never reset.
// Ports:
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (combinational from raddr)
module fifo_mem #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: single-clock FIFO with occupancy count, almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
// Optional feature macro: FIFO_FWFT_EN (first-word-fall-through read port).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   w_en, wdata     write request and data
//   r_en            read request (pop)
//   rdata           read data (registered, or head word in FWFT builds)
//   rdata_valid     rdata holds a valid word
//   w_full          count == MEMORY_DEPTH
//   w_almost_full   count >= ALMOST_FULL_TH
//   r_empty         count == 0
//   r_almost_empty  count <= ALMOST_EMPTY_TH
//   count           current occupancy
//   overflow        sticky: write attempted while full
//   underflow       sticky: read attempted while empty
module fifo_sync_ctrl
   import fifo_pkg::*;
#(
   parameter int MEMORY_WIDTH    = 4,
   parameter int MEMORY_DEPTH    = 4,
   parameter int ADDRESS_SIZE    = 2,
   parameter int ALMOST_FULL_TH  = 3,
   parameter int ALMOST_EMPTY_TH = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    w_en,
   input  logic [MEMORY_WIDTH-1:0] wdata,
   input  logic                    r_en,
   output logic [MEMORY_WIDTH-1:0] rdata,
   output logic                    rdata_valid,
   output logic                    w_full,
   output logic                    w_almost_full,
   output logic                    r_empty,
   output logic                    r_almost_empty,
   output logic [ADDRESS_SIZE:0]   count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int CW = count_width(ADDRESS_SIZE);

   logic [ADDRESS_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    overflow_q, overflow_d;
   logic                    underflow_q, underflow_d;
   logic                    wr_acc, rd_acc;
   logic [MEMORY_WIDTH-1:0] mem_rdata;

   // Status is a pure decode of the registered count.
   assign w_full         = (count_q == CW'(MEMORY_DEPTH));
   assign w_almost_full  = (count_q >= CW'(ALMOST_FULL_TH));
   assign r_empty        = (count_q == '0);
   assign r_almost_empty = (count_q <= CW'(ALMOST_EMPTY_TH));
   assign count          = count_q;
   assign overflow       = overflow_q;
   assign underflow      = underflow_q;

   // Acceptance looks only at the current flags: a concurrent pop does not
   // make room for a write in the same cycle, nor a push feed a read.
   assign wr_acc = w_en && !w_full;
   assign rd_acc = r_en && !r_empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (wr_acc) begin
         wr_ptr_d = ADDRESS_SIZE'(ptr_inc(32'(wr_ptr_q), MEMORY_DEPTH));
      end
      if (rd_acc) begin
         rd_ptr_d = ADDRESS_SIZE'(ptr_inc(32'(rd_ptr_q), MEMORY_DEPTH));
      end
      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
      overflow_d  = overflow_q | (w_en & w_full);
      underflow_d = underflow_q | (r_en & r_empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem #(
      .WIDTH (MEMORY_WIDTH),
      .DEPTH (MEMORY_DEPTH),
      .AW    (ADDRESS_SIZE)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

`ifdef FIFO_FWFT_EN
   // Head word is always on the bus; r_en just acknowledges it.
   assign rdata       = mem_rdata;
   assign rdata_valid = !r_empty;
`else
   logic [MEMORY_WIDTH-1:0] rdata_q, rdata_d;
   logic                    rdata_valid_q, rdata_valid_d;

   // rdata holds the last popped word until the next accepted read.
   always_comb begin
      rdata_d       = rdata_q;
      rdata_valid_d = rd_acc;
      if (rd_acc) begin
         rdata_d = mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
      end
   end

   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl: randomized and directed checks of fifo_sync_ctrl against
// a queue-based reference model. Builds with or without FIFO_FWFT_EN.
module tb_fifo_sync_ctrl;

   localparam int W     = 4;
   localparam int DEPTH = 4;
   localparam int AF_TH = 3;
   localparam int AE_TH = 1;

   logic         clk;
   logic         rst;
   logic         w_en;
   logic [W-1:0] wdata;
   logic         r_en;
   logic [W-1:0] rdata;
   logic         rdata_valid;
   logic         w_full;
   logic         w_almost_full;
   logic         r_empty;
   logic         r_almost_empty;
   logic [2:0]   count;
   logic         overflow;
   logic         underflow;

   fifo_sync_ctrl #(
      .MEMORY_WIDTH    (W),
      .MEMORY_DEPTH    (DEPTH),
      .ADDRESS_SIZE    (2),
      .ALMOST_FULL_TH  (AF_TH),
      .ALMOST_EMPTY_TH (AE_TH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .w_en           (w_en),
      .wdata          (wdata),
      .r_en           (r_en),
      .rdata          (rdata),
      .rdata_valid    (rdata_valid),
      .w_full         (w_full),
      .w_almost_full  (w_almost_full),
      .r_empty        (r_empty),
      .r_almost_empty (r_almost_empty),
      .count          (count),
      .overflow       (overflow),
      .underflow      (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // Reference model: contents as a queue, plus sticky flags and read register.
   logic [W-1:0] mq[$];
   logic         m_ovf   = 1'b0;
   logic         m_unf   = 1'b0;
   logic [W-1:0] m_rdata = '0;
   logic         m_valid = 1'b0;

   logic [13:0] dut_status;
   assign dut_status = {count, w_full, w_almost_full, r_empty, r_almost_empty,
                        overflow, underflow, rdata_valid, rdata};

   function automatic logic [13:0] exp_status();
      int           n;
      logic [W-1:0] rd;
      logic         vld;
      n = mq.size();
`ifdef FIFO_FWFT_EN
      rd  = (n > 0) ? mq[0] : '0;
      vld = (n > 0);
`else
      rd  = m_rdata;
      vld = m_valid;
`endif
      return {3'(n), (n == DEPTH), (n >= AF_TH), (n == 0), (n <= AE_TH),
              m_ovf, m_unf, vld, rd};
   endfunction

   // In FWFT builds the bus shows stale memory while empty; ignore it there.
   function automatic logic [13:0] status_mask();
`ifdef FIFO_FWFT_EN
      return (mq.size() == 0) ? 14'h3FF0 : 14'h3FFF;
`else
      return 14'h3FFF;
`endif
   endfunction

   // Drive one cycle of stimulus and advance the model at the same edge.
   task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic rs);
      int n;
      w_en  = w;
      wdata = d;
      r_en  = r;
      rst   = rs;
      @(posedge clk);
      n = mq.size();
      if (rs) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
         m_rdata = '0;
         m_valid = 1'b0;
      end else begin
         if (w && n == DEPTH) m_ovf = 1'b1;
         if (r && n == 0)     m_unf = 1'b1;
         m_valid = 1'b0;
         if (r && n > 0) begin
            m_rdata = mq.pop_front();
            m_valid = 1'b1;
         end
         if (w && n < DEPTH) mq.push_back(d);
      end
      #1;
      w_en = 1'b0;
      r_en = 1'b0;
      rst  = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      total++;
      if ((dut_status & status_mask()) !== (exp_status() & status_mask())) begin
         bad++;
         $display("FAIL reset_status: got %h expected %h", dut_status, exp_status());
      end
      total++;
      if ({count, r_empty, r_almost_empty, w_full, w_almost_full, overflow, underflow, rdata_valid}
          !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_values: count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b v=%b",
                  count, r_empty, r_almost_empty, w_full, w_almost_full, overflow, underflow, rdata_valid);
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, W'(i), 1'b0, 1'b0);
         total++;
         if (dut_status !== exp_status()) begin
            bad++;
            $display("FAIL fill_status_%0d: got %h expected %h", i, dut_status, exp_status());
         end
         total++;
         if (count !== 3'((i > 4) ? 4 : i)) begin
            bad++;
            $display("FAIL fill_count_%0d: got %0d expected %0d", i, count, (i > 4) ? 4 : i);
         end
         total++;
         if ({w_almost_full, w_full, overflow} !== {(i >= 3), (i >= 4), (i >= 5)}) begin
            bad++;
            $display("FAIL fill_flags_%0d: af/full/ovf got %b%b%b", i, w_almost_full, w_full, overflow);
         end
      end
   endtask

`ifndef FIFO_FWFT_EN
   task automatic test_drain();
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         total++;
         if ({rdata_valid, rdata} !== {1'b1, W'(i)}) begin
            bad++;
            $display("FAIL drain_word_%0d: got v=%b d=%0d expected v=1 d=%0d", i, rdata_valid, rdata, i);
         end
      end
      total++;
      if (r_empty !== 1'b1) begin
         bad++;
         $display("FAIL drain_empty: got %b expected 1", r_empty);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      total++;
      if ({underflow, rdata_valid, rdata} !== {1'b1, 1'b0, W'(4)}) begin
         bad++;
         $display("FAIL drain_underflow: got un=%b v=%b d=%0d expected 1 0 4", underflow, rdata_valid, rdata);
      end
      total++;
      if (dut_status !== exp_status()) begin
         bad++;
         $display("FAIL drain_status: got %h expected %h", dut_status, exp_status());
      end
   endtask
`endif

   task automatic test_wrap();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, W'(1), 1'b0, 1'b0);
      for (int i = 2; i <= 6; i++) begin
         step(1'b1, W'(i), 1'b1, 1'b0);
         total++;
         if ({count, overflow} !== {3'd1, 1'b0}) begin
            bad++;
            $display("FAIL wrap_count_%0d: got count=%0d ovf=%b expected 1 0", i, count, overflow);
         end
`ifdef FIFO_FWFT_EN
         total++;
         if (rdata !== W'(i)) begin
            bad++;
            $display("FAIL wrap_head_%0d: got %0d expected %0d", i, rdata, i);
         end
`else
         total++;
         if (rdata !== W'(i - 1)) begin
            bad++;
            $display("FAIL wrap_data_%0d: got %0d expected %0d", i, rdata, i - 1);
         end
`endif
      end
      step(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (dut_status !== (exp_status() & status_mask() | dut_status & ~status_mask())) begin
         bad++;
         $display("FAIL wrap_final: got %h expected %h", dut_status, exp_status());
      end
   endtask

   task automatic test_full_simul();
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, W'($urandom_range(0, 15)), 1'b0, 1'b0);
      step(1'b1, W'(4'hA), 1'b1, 1'b0);
      total++;
      if ({count, overflow} !== {3'd3, 1'b1}) begin
         bad++;
         $display("FAIL full_simul: got count=%0d ovf=%b expected 3 1", count, overflow);
      end
      total++;
      if ((dut_status & status_mask()) !== (exp_status() & status_mask())) begin
         bad++;
         $display("FAIL full_simul_status: got %h expected %h", dut_status, exp_status());
      end
   endtask

   task automatic test_random();
      logic rs;
      for (int c = 0; c < 400; c++) begin
         rs = ($urandom_range(0, 59) == 0);
         step(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rs);
         total++;
         if ((dut_status & status_mask()) !== (exp_status() & status_mask())) begin
            bad++;
            $display("FAIL random_%0d: got %h expected %h", c, dut_status, exp_status());
         end
      end
   endtask

`ifdef FIFO_FWFT_EN
   task automatic test_fwft();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, W'(9), 1'b0, 1'b0);
      total++;
      if ({rdata_valid, rdata} !== {1'b1, W'(9)}) begin
         bad++;
         $display("FAIL fwft_show: got v=%b d=%0d expected 1 9", rdata_valid, rdata);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (rdata_valid !== 1'b0) begin
         bad++;
         $display("FAIL fwft_pop: got v=%b expected 0", rdata_valid);
      end
      step(1'b1, W'(3), 1'b0, 1'b0);
      step(1'b1, W'(7), 1'b1, 1'b1);
      total++;
      if ({count, rdata_valid, r_empty, overflow, underflow} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL fwft_reset: got count=%0d v=%b e=%b", count, rdata_valid, r_empty);
      end
   endtask
`endif

   initial begin
      rst   = 1'b1;
      w_en  = 1'b0;
      r_en  = 1'b0;
      wdata = '0;
      test_reset();
      test_fill();
`ifndef FIFO_FWFT_EN
      test_drain();
`endif
      test_wrap();
      test_full_simul();
      test_random();
`ifdef FIFO_FWFT_EN
      test_fwft();
`endif
      test_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
